ntt_ctrl: RTL and testbench

Sequencer that runs a complete in-place N-point forward (NTT, Cooley-Tukey) or inverse (INTT, Gentleman-Sande) transform over a coefficient RAM. It uses one `butterfly` instance as its datapath. `ntt_ctrl` is the initiator side of the butterfly interface and owns the following:
- read and twiddle address generation;
- operand skew alignment, to match the butterfly's mixed combinational/registered paths;
- write-back addressing;
- stage drain and completion signalling.

It sits between the host start/done handshake and the coefficient RAM, twiddle ROM and butterfly.

---
 rtl/ntt_pkg.sv | 19 +
 rtl/ntt_addr_gen.sv | 33 +++
 rtl/ntt_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ntt_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants for the NTT sequencer: butterfly mode codes, sequencer state encoding
// and the fixed coefficient width.
package ntt_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] BF_NTT    = 2'b00;
  localparam logic [1:0] BF_INTT   = 2'b01;
  localparam logic [1:0] BF_BYPASS = 2'b10;
  localparam logic [1:0] BF_IDLE   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } ntt_state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational address generator: (stage, butterfly index, mode) -> read pair and twiddle index.
// All divisions by len are shifts because len is always a power of two.
module ntt_addr_gen #(
  parameter int LOGN = 8,
  parameter int SW   = 3
) (
  input  logic [SW-1:0]   s,
  input  logic [LOGN-1:0] i,
  input  logic            mode,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-1:0] tw_addr
);

  localparam logic [SW-1:0] S_MAX = SW'(LOGN - 1);

  logic [SW-1:0]   sh;
  logic [LOGN-1:0] len;
  logic [LOGN-1:0] g;
  logic [LOGN-1:0] j;

  // sh = log2(len); both transforms share the twiddle base 1 << (LOGN-1-sh)
  always_comb begin
    sh      = mode ? s : (S_MAX - s);
    len     = LOGN'(1) << sh;
    g       = i >> sh;
    j       = ((g << sh) << 1) | (i & (len - LOGN'(1)));
    addr_a  = j;
    addr_b  = j | len;
    tw_addr = (LOGN'(1) << (S_MAX - sh)) + g;
  end

endmodule

// File: rtl/ntt_ctrl.sv
// In-place NTT (Cooley-Tukey) / INTT (Gentleman-Sande) sequencer for an external butterfly.
// Defining NTT_CTRL_PERF_EN adds a saturating busy-cycle counter on port cycle_cnt.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one butterfly pair issued per cycle, N/2 per stage
// DRAIN | BF_LAT+1 cycles so the stage's write-backs land before the next stage reads
// DONE  | one-cycle completion pulse; a start seen here is accepted like in IDLE
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int LOGN   = 8,
  parameter int BF_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_i,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [LOGN-1:0]   rd_addr_a,
  output logic [LOGN-1:0]   rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic [LOGN-1:0]   tw_addr,
  input  logic [DATA_W-1:0] tw_data,
  output logic              wr_en,
  output logic [LOGN-1:0]   wr_addr_a,
  output logic [LOGN-1:0]   wr_addr_b,
  output logic [DATA_W-1:0] wr_data_a,
  output logic [DATA_W-1:0] wr_data_b,
`ifdef NTT_CTRL_PERF_EN
  output logic [31:0]       cycle_cnt,
`endif
  output logic [1:0]        bf_mode,
  output logic [DATA_W-1:0] bf_a,
  output logic [DATA_W-1:0] bf_b,
  output logic [DATA_W-1:0] bf_w,
  input  logic [DATA_W-1:0] bf_c,
  input  logic [DATA_W-1:0] bf_d
);

  localparam int N  = 1 << LOGN;
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int DW = $clog2(BF_LAT + 1);
  localparam logic [LOGN-1:0] I_LAST = LOGN'(N / 2 - 1);
  localparam logic [SW-1:0]   S_LAST = SW'(LOGN - 1);

  ntt_state_e      state;
  logic [SW-1:0]   s_cnt;
  logic [LOGN-1:0] i_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            mode_q;
  logic            accept;

  logic [LOGN-1:0] ag_a, ag_b, ag_tw;

  logic [BF_LAT:0]    vld_sr;
  logic [LOGN-1:0]    wa_sr [BF_LAT+1];
  logic [LOGN-1:0]    wb_sr [BF_LAT+1];
  logic [DATA_W-1:0]  a_dly [BF_LAT];
  logic [DATA_W-1:0]  c_dly [BF_LAT];
  logic               data_vld;
  logic [DATA_W-1:0]  rd_a_g, rd_b_g;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  ntt_addr_gen #(
    .LOGN (LOGN),
    .SW   (SW)
  ) u_addr_gen (
    .s       (s_cnt),
    .i       (i_cnt),
    .mode    (mode_q),
    .addr_a  (ag_a),
    .addr_b  (ag_b),
    .tw_addr (ag_tw)
  );

  assign rd_addr_a = rd_en ? ag_a  : '0;
  assign rd_addr_b = rd_en ? ag_b  : '0;
  assign tw_addr   = rd_en ? ag_tw : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      s_cnt     <= '0;
      i_cnt     <= '0;
      drain_cnt <= '0;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      bf_mode   <= BF_IDLE;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state   <= S_RUN;
            mode_q  <= mode_i;
            s_cnt   <= '0;
            i_cnt   <= '0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            bf_mode <= {1'b0, mode_i};
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (i_cnt == I_LAST) begin
            state     <= S_DRAIN;
            i_cnt     <= '0;
            rd_en     <= 1'b0;
            drain_cnt <= DW'(BF_LAT);
          end else begin
            i_cnt <= i_cnt + LOGN'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            if (s_cnt == S_LAST) begin
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              bf_mode <= BF_IDLE;
            end else begin
              state <= S_RUN;
              s_cnt <= s_cnt + SW'(1);
              rd_en <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // vld_sr[0] marks RAM/ROM data valid for the pair issued last cycle
  assign data_vld = vld_sr[0];
  assign rd_a_g   = data_vld ? rd_data_a : '0;
  assign rd_b_g   = data_vld ? rd_data_b : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
      for (int k = 0; k <= BF_LAT; k++) begin
        wa_sr[k] <= '0;
        wb_sr[k] <= '0;
      end
      for (int k = 0; k < BF_LAT; k++) begin
        a_dly[k] <= '0;
        c_dly[k] <= '0;
      end
    end else begin
      vld_sr   <= {vld_sr[BF_LAT-1:0], rd_en};
      wa_sr[0] <= rd_addr_a;
      wb_sr[0] <= rd_addr_b;
      for (int k = 1; k <= BF_LAT; k++) begin
        wa_sr[k] <= wa_sr[k-1];
        wb_sr[k] <= wb_sr[k-1];
      end
      a_dly[0] <= mode_q ? '0 : rd_a_g;
      c_dly[0] <= (data_vld && mode_q) ? bf_c : '0;
      for (int k = 1; k < BF_LAT; k++) begin
        a_dly[k] <= a_dly[k-1];
        c_dly[k] <= c_dly[k-1];
      end
    end
  end

  // NTT: a waits for the b*w product; INTT: c is ready early and waits for d
  assign bf_a = mode_q ? rd_a_g : a_dly[BF_LAT-1];
  assign bf_b = rd_b_g;
  assign bf_w = data_vld ? tw_data : '0;

  assign wr_en     = vld_sr[BF_LAT];
  assign wr_addr_a = wa_sr[BF_LAT];
  assign wr_addr_b = wb_sr[BF_LAT];
  assign wr_data_a = wr_en ? (mode_q ? c_dly[BF_LAT-1] : bf_c) : '0;
  assign wr_data_b = wr_en ? bf_d : '0;

`ifdef NTT_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (accept) begin
      cycle_cnt <= '0;
    end else if (busy && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl (LOGN=3, BF_LAT=3) with a modular butterfly, RAM and twiddle ROM model;
// results are compared against a loop-based transform computed in the bench.
module tb_ntt_ctrl;

  localparam int LOGN   = 3;
  localparam int BF_LAT = 3;
  localparam int N      = 1 << LOGN;
  localparam int unsigned Q = 12289;
  localparam int DONE_CYC = LOGN * (N / 2 + BF_LAT + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic mode_i = 1'b0;
  logic busy, done, rd_en, wr_en;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
  logic [15:0] rd_data_a, rd_data_b, tw_data, wr_data_a, wr_data_b;
  logic [1:0]  bf_mode;
  logic [15:0] bf_a, bf_b, bf_w, bf_c, bf_d;
`ifdef NTT_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
`endif

  always #5 clk = ~clk;

  ntt_ctrl #(.LOGN(LOGN), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode_i    (mode_i),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .tw_addr   (tw_addr),
    .tw_data   (tw_data),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_data_a (wr_data_a),
    .wr_data_b (wr_data_b),
`ifdef NTT_CTRL_PERF_EN
    .cycle_cnt (cycle_cnt),
`endif
    .bf_mode   (bf_mode),
    .bf_a      (bf_a),
    .bf_b      (bf_b),
    .bf_w      (bf_w),
    .bf_c      (bf_c),
    .bf_d      (bf_d)
  );

  function automatic int unsigned addm(input int unsigned x, input int unsigned y);
    return (x + y) % Q;
  endfunction
  function automatic int unsigned subm(input int unsigned x, input int unsigned y);
    return (x + Q - y) % Q;
  endfunction
  function automatic int unsigned mulm(input int unsigned x, input int unsigned y);
    return (x * y) % Q;
  endfunction
  function automatic int unsigned negm(input int unsigned x);
    return (Q - x) % Q;
  endfunction

  // Coefficient RAM / twiddle ROM, both with one cycle read latency
  logic [15:0] ram [N];
  logic [15:0] rom [N];
  logic [15:0] img [N];
  logic        load_req = 1'b0;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= ram[rd_addr_a];
      rd_data_b <= ram[rd_addr_b];
    end
    tw_data <= rom[tw_addr];
    if (load_req) begin
      for (int k = 0; k < N; k++) ram[k] = img[k];
    end else if (wr_en) begin
      ram[wr_addr_a] = wr_data_a;
      ram[wr_addr_b] = wr_data_b;
    end
  end

  // Butterfly model: registered multiply path of BF_LAT cycles, combinational add path
  int unsigned pipe [BF_LAT];
  always @(posedge clk) begin
    if (bf_mode == 2'b01) pipe[0] <= mulm(subm(32'(bf_a), 32'(bf_b)), negm(32'(bf_w)));
    else                  pipe[0] <= mulm(32'(bf_b), 32'(bf_w));
    for (int k = 1; k < BF_LAT; k++) pipe[k] <= pipe[k-1];
  end

  always_comb begin
    bf_c = '0;
    bf_d = '0;
    if (bf_mode == 2'b00) begin
      bf_c = 16'(addm(32'(bf_a), pipe[BF_LAT-1]));
      bf_d = 16'(subm(32'(bf_a), pipe[BF_LAT-1]));
    end else if (bf_mode == 2'b01) begin
      bf_c = 16'(addm(32'(bf_a), 32'(bf_b)));
      bf_d = 16'(pipe[BF_LAT-1]);
    end
  end

  // Interface monitor
  logic [3*LOGN-1:0] iss_q [$];
  int wr_cnt = 0;
  int hazard_cnt = 0;
  always @(negedge clk) begin
    if (rd_en) iss_q.push_back({rd_addr_a, rd_addr_b, tw_addr});
    if (wr_en) wr_cnt++;
    if (rd_en && wr_en && (rd_addr_a == wr_addr_a || rd_addr_a == wr_addr_b ||
                           rd_addr_b == wr_addr_a || rd_addr_b == wr_addr_b))
      hazard_cnt++;
  end

  int passed = 0;
  int total  = 0;
  int unsigned ref_mem [N];
  logic [3*LOGN-1:0] exp_iss [$];
  int last_iss0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3*LOGN-1:0] pr(input int a, input int b, input int t);
    return {LOGN'(a), LOGN'(b), LOGN'(t)};
  endfunction

  // Reference transform written straight from the group/len formulation
  task automatic ref_xform(input bit inv);
    exp_iss.delete();
    for (int k = 0; k < N; k++) ref_mem[k] = 32'(img[k]);
    for (int s = 0; s < LOGN; s++) begin
      int len;
      len = inv ? (1 << s) : (N >> (s + 1));
      for (int g = 0; g < N / (2 * len); g++) begin
        int t;
        int unsigned w;
        t = inv ? (N >> (s + 1)) + g : (1 << s) + g;
        w = 32'(rom[t]);
        for (int k = 0; k < len; k++) begin
          int j;
          int unsigned x, y;
          j = g * 2 * len + k;
          x = ref_mem[j];
          y = ref_mem[j + len];
          if (!inv) begin
            ref_mem[j]       = addm(x, mulm(w, y));
            ref_mem[j + len] = subm(x, mulm(w, y));
          end else begin
            ref_mem[j]       = addm(x, y);
            ref_mem[j + len] = mulm(subm(x, y), negm(w));
          end
          exp_iss.push_back(pr(j, j + len, t));
        end
      end
    end
  endtask

  task automatic load_ram(input bit impulse);
    for (int k = 0; k < N; k++)
      img[k] = impulse ? ((k == 0) ? 16'd1 : 16'd0) : 16'($urandom_range(Q - 1, 0));
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_xform(input bit m, input int glitch, input string tag);
    int done_c, busy_c, mode_bad, wr0, hz0, iss_bad, ram_bad;
    done_c = 0; busy_c = 0; mode_bad = 0; iss_bad = 0; ram_bad = 0;
    ref_xform(m);
    wr0 = wr_cnt;
    hz0 = hazard_cnt;
    last_iss0 = iss_q.size();
    @(negedge clk);
    start = 1'b1;
    mode_i = m;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= DONE_CYC + 20 && done_c == 0; n++) begin
      @(negedge clk);
      if (busy) begin
        busy_c++;
        if (bf_mode != {1'b0, m}) mode_bad++;
      end
      if (done) done_c = n;
      start = (n == glitch);
      if (n == glitch) mode_i = ~m;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_c), 32'(DONE_CYC));
    check({tag, "_busy_cycles"}, 32'(busy_c), 32'(DONE_CYC - 1));
    check({tag, "_bf_mode_bad"}, 32'(mode_bad), 32'd0);
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    check({tag, "_bf_mode_idle"}, {30'd0, bf_mode}, 32'd3);
    check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(LOGN * N / 2));
    check({tag, "_rw_overlap"}, 32'(hazard_cnt - hz0), 32'd0);
    check({tag, "_issue_count"}, 32'(iss_q.size() - last_iss0), 32'(exp_iss.size()));
    for (int k = 0; k < exp_iss.size() && last_iss0 + k < iss_q.size(); k++)
      if (iss_q[last_iss0 + k] !== exp_iss[k]) iss_bad++;
    check({tag, "_issue_order"}, 32'(iss_bad), 32'd0);
    for (int k = 0; k < N; k++)
      if (32'(ram[k]) !== ref_mem[k]) ram_bad++;
    check({tag, "_ram_result"}, 32'(ram_bad), 32'd0);
  endtask

  initial begin
    int stray;
    for (int k = 0; k < N; k++) rom[k] = 16'($urandom_range(Q - 1, 0));

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_bf_mode", {30'd0, bf_mode}, 32'd3);
    check("rst_rd_addr", {26'd0, rd_addr_a, rd_addr_b}, 32'd0);
    check("rst_wr_data", {wr_data_a, wr_data_b}, 32'd0);
    check("rst_bf_ops", {bf_a, bf_b | bf_w}, 32'd0);
    rst = 1'b1;

    // random NTT
    load_ram(1'b0);
    run_xform(1'b0, -1, "ntt");
    check("ntt_s0_first", 32'(iss_q[last_iss0 + 0]), 32'(pr(0, 4, 1)));
    check("ntt_s0_last", 32'(iss_q[last_iss0 + 3]), 32'(pr(3, 7, 1)));
    check("ntt_s1_grp1", 32'(iss_q[last_iss0 + 6]), 32'(pr(4, 6, 3)));
    check("ntt_s2_last", 32'(iss_q[last_iss0 + 11]), 32'(pr(6, 7, 7)));
`ifdef NTT_CTRL_PERF_EN
    check("perf_cycle_cnt", cycle_cnt, 32'd24);
    repeat (5) @(negedge clk);
    check("perf_cycle_hold", cycle_cnt, 32'd24);
`endif

    // random INTT
    for (int k = 0; k < N; k++) rom[k] = 16'($urandom_range(Q - 1, 0));
    load_ram(1'b0);
    run_xform(1'b1, -1, "intt");
    check("intt_s0_first", 32'(iss_q[last_iss0 + 0]), 32'(pr(0, 1, 4)));
    check("intt_s0_last", 32'(iss_q[last_iss0 + 3]), 32'(pr(6, 7, 7)));
    check("intt_s1_grp1", 32'(iss_q[last_iss0 + 6]), 32'(pr(4, 6, 3)));
    check("intt_s2_last", 32'(iss_q[last_iss0 + 11]), 32'(pr(3, 7, 1)));

    // impulse with unit twiddles -> all ones
    for (int k = 0; k < N; k++) rom[k] = 16'd1;
    load_ram(1'b1);
    run_xform(1'b0, -1, "ones");
    for (int k = 0; k < N; k++) check($sformatf("ones_ram%0d", k), {16'd0, ram[k]}, 32'd1);

    // asynchronous reset during stage 1 write-back
    for (int k = 0; k < N; k++) rom[k] = 16'($urandom_range(Q - 1, 0));
    load_ram(1'b0);
    @(negedge clk);
    start = 1'b1;
    mode_i = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_bf_mode", {30'd0, bf_mode}, 32'd3);
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || wr_en || busy || rd_en) stray++;
    end
    check("post_rst_quiet", 32'(stray), 32'd0);
    load_ram(1'b0);
    run_xform(1'b0, -1, "after_rst");

    // start and mode_i toggled while busy
    load_ram(1'b0);
    run_xform(1'b1, 10, "glitch");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
